// File: rtl/matrix_max_pool_pkg.sv
// matrix_max_pool_pkg: shared bus encodings and memory layout constants for the conv/pool stages
package matrix_max_pool_pkg;
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;
  localparam logic [31:0] ADDR_WA = 32'd1;
  localparam logic [31:0] ADDR_HA = 32'd2;
  localparam logic [31:0] ADDR_WF = 32'd3;
  localparam logic [31:0] ADDR_HF = 32'd4;
  localparam int PARAM_BASE_DEF = 6;
  typedef enum logic [2:0] {
    IDLE,
    FETCH_PARAMS,
    CHECK,
    WIN_INIT,
    READ_ELEM,
    WRITE_OUT,
    FSM_DONE
  } pool_state_t;
endpackage

// File: rtl/matrix_max_pool_layout_calc.sv
// matrix_layout_calc: derives result and pooled matrix geometry from the parameter block
module matrix_layout_calc
  import matrix_max_pool_pkg::*;
#(
  parameter int POOL       = 2,
  parameter int PARAM_BASE = PARAM_BASE_DEF
) (
  input  logic [31:0] wa,
  input  logic [31:0] ha,
  input  logic [31:0] wf,
  input  logic [31:0] hf,
  output logic [31:0] rw,
  output logic [31:0] rh,
  output logic [31:0] r_base,
  output logic [31:0] pw,
  output logic [31:0] ph,
  output logic [31:0] p_base
);
  localparam logic [31:0] POOL_W = 32'(POOL);
  localparam logic [31:0] BASE_W = 32'(PARAM_BASE);
  // result matrix sits after A, B (same size as A) and the filter
  always_comb begin
    rw     = wa - wf + 32'd1;
    rh     = ha - hf + 32'd1;
    r_base = BASE_W + 32'd2 * wa * ha + wf * hf;
    pw     = rw / POOL_W;
    ph     = rh / POOL_W;
    p_base = r_base + rw * rh;
  end
endmodule

// File: rtl/matrix_max_pool.sv
// matrix_max_pool: max-pools the convolution result in RAM and writes the pooled matrix after it
module matrix_max_pool
  import matrix_max_pool_pkg::*;
#(
  parameter int POOL       = 2,
  parameter bit RELU       = 1'b1,
  parameter int PARAM_BASE = PARAM_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mem_opdone,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] addr_o,
  output logic [1:0]  mem_operation,
  output logic        done
);
  localparam logic [31:0] POOL_W = 32'(POOL);
  pool_state_t state, state_n;
  logic [1:0] op_n, idx, idx_n;
  logic [31:0] addr_n, data_n;
  logic [3:0][31:0] prm, prm_n;
  logic [31:0] rw, pw, ph, r_base, p_base, rw_n, pw_n, ph_n, rb_n, pb_n;
  logic [31:0] c_rw, c_rh, c_rb, c_pw, c_ph, c_pb;
  logic [31:0] pr, pc, wr, wc, pr_n, pc_n, wr_n, wc_n, mx, mx_n;
  logic [31:0] wa, ha, wf, hf, elem_addr, out_addr;
  logic first, first_n, bad, last_wc, last_wr, last_pc, last_pr;
  assign {wa, ha, wf, hf} = prm;
  assign done = state == FSM_DONE;
  assign bad = wf > wa || hf > ha || wf == '0 || hf == '0 || c_rw < POOL_W || c_rh < POOL_W;
  assign elem_addr = r_base + (POOL_W * pr + wr) * rw + POOL_W * pc + wc;
  assign out_addr = p_base + pr * pw + pc;
  assign last_wc = wc == POOL_W - 32'd1;
  assign last_wr = wr == POOL_W - 32'd1;
  assign last_pc = pc == pw - 32'd1;
  assign last_pr = pr == ph - 32'd1;
  matrix_layout_calc #(.POOL(POOL), .PARAM_BASE(PARAM_BASE)) u_calc (
    .wa(wa), .ha(ha), .wf(wf), .hf(hf),
    .rw(c_rw), .rh(c_rh), .r_base(c_rb), .pw(c_pw), .ph(c_ph), .p_base(c_pb)
  );
  // next-state: each bus state issues when the bus is idle and retires on opdone
  always_comb begin
    state_n = state;
    op_n = mem_operation;
    addr_n = addr_o;
    data_n = data_o;
    idx_n = idx;
    prm_n = prm;
    rw_n = rw;
    pw_n = pw;
    ph_n = ph;
    rb_n = r_base;
    pb_n = p_base;
    pr_n = pr;
    pc_n = pc;
    wr_n = wr;
    wc_n = wc;
    first_n = first;
    mx_n = mx;
    if (!enable) begin
      state_n = IDLE;
      op_n = MEM_NONE;
      addr_n = '0;
      data_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = FETCH_PARAMS;
          idx_n = '0;
        end
        FETCH_PARAMS:
          if (mem_operation == MEM_NONE) begin
            op_n = MEM_READ;
            addr_n = ADDR_WA + 32'(idx);
          end else if (mem_opdone) begin
            op_n = MEM_NONE;
            prm_n = {prm[2:0], data_i};
            idx_n = idx + 2'd1;
            state_n = idx == 2'd3 ? CHECK : FETCH_PARAMS;
          end
        CHECK: begin
          rw_n = c_rw;
          pw_n = c_pw;
          ph_n = c_ph;
          rb_n = c_rb;
          pb_n = c_pb;
          pr_n = '0;
          pc_n = '0;
          state_n = bad ? FSM_DONE : WIN_INIT;
        end
        WIN_INIT: begin
          wr_n = '0;
          wc_n = '0;
          first_n = 1'b1;
          state_n = READ_ELEM;
        end
        READ_ELEM:
          if (mem_operation == MEM_NONE) begin
            op_n = MEM_READ;
            addr_n = elem_addr;
          end else if (mem_opdone) begin
            op_n = MEM_NONE;
            mx_n = (first || $signed(data_i) > $signed(mx)) ? data_i : mx;
            first_n = 1'b0;
            wc_n = last_wc ? '0 : wc + 32'd1;
            wr_n = last_wc ? wr + 32'd1 : wr;
            state_n = (last_wc && last_wr) ? WRITE_OUT : READ_ELEM;
          end
        WRITE_OUT:
          if (mem_operation == MEM_NONE) begin
            op_n = MEM_WRITE;
            addr_n = out_addr;
            data_n = (RELU && mx[31]) ? '0 : mx;
          end else if (mem_opdone) begin
            op_n = MEM_NONE;
            pc_n = last_pc ? '0 : pc + 32'd1;
            pr_n = last_pc ? pr + 32'd1 : pr;
            state_n = (last_pc && last_pr) ? FSM_DONE : WIN_INIT;
          end
        default: ;
      endcase
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mem_operation <= MEM_NONE;
      addr_o <= '0;
      data_o <= '0;
      idx <= '0;
      prm <= '0;
      rw <= '0;
      pw <= '0;
      ph <= '0;
      r_base <= '0;
      p_base <= '0;
      pr <= '0;
      pc <= '0;
      wr <= '0;
      wc <= '0;
      first <= 1'b0;
      mx <= '0;
    end else begin
      state <= state_n;
      mem_operation <= op_n;
      addr_o <= addr_n;
      data_o <= data_n;
      idx <= idx_n;
      prm <= prm_n;
      rw <= rw_n;
      pw <= pw_n;
      ph <= ph_n;
      r_base <= rb_n;
      p_base <= pb_n;
      pr <= pr_n;
      pc <= pc_n;
      wr <= wr_n;
      wc <= wc_n;
      first <= first_n;
      mx <= mx_n;
    end
endmodule

// File: tb/tb_matrix_max_pool.sv
// tb_matrix_max_pool: directed vectors against a behavioural word memory with optional opdone delay
module tb_matrix_max_pool;
  logic clk = 1'b0, reset_n = 1'b0, en0 = 1'b0, en1 = 1'b0, sel = 1'b0, mem_opdone = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] do0, ad0, do1, ad1, addr_m, data_m, s_a, s_d;
  logic [1:0] op0, op1, op_m, s_op;
  logic dn0, dn1, od0, od1, done_m, pend;
  logic [31:0] mem [0:255];
  logic [31:0] wr_a[$], wr_d[$], rd_a[$], exp_a[$], exp_d[$];
  int checks = 0, errors = 0, max_dly = 0, cnt = 0, bad = 0;
  always #5 clk = ~clk;
  assign op_m = sel ? op1 : op0;
  assign addr_m = sel ? ad1 : ad0;
  assign data_m = sel ? do1 : do0;
  assign done_m = sel ? dn1 : dn0;
  assign od0 = mem_opdone & ~sel;
  assign od1 = mem_opdone & sel;
  matrix_max_pool #(.POOL(2), .RELU(1'b1), .PARAM_BASE(6)) u_relu (
    .clk(clk), .reset_n(reset_n), .enable(en0), .mem_opdone(od0), .data_i(data_i),
    .data_o(do0), .addr_o(ad0), .mem_operation(op0), .done(dn0)
  );
  matrix_max_pool #(.POOL(2), .RELU(1'b0), .PARAM_BASE(6)) u_raw (
    .clk(clk), .reset_n(reset_n), .enable(en1), .mem_opdone(od1), .data_i(data_i),
    .data_o(do1), .addr_o(ad1), .mem_operation(op1), .done(dn1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic setup(input logic [31:0] wa, input logic [31:0] ha, input logic [31:0] wf, input logic [31:0] hf);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = wa;
    mem[2] = ha;
    mem[3] = wf;
    mem[4] = hf;
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
  endtask
  task automatic run(input string tag);
    for (int i = 0; i < 4000 && !done_m; i++) @(negedge clk);
    chk({tag, "_done"}, 32'(done_m), 32'd1);
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), wr_a[i], exp_a[i]);
      chk($sformatf("%s_wd%0d", tag, i), wr_d[i], exp_d[i]);
    end
  endtask
  task automatic stop();
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic load_t1();
    setup(4, 4, 1, 1);
    for (int i = 0; i < 16; i++) mem[39 + i] = 32'(i + 1);
    exp_a = '{55, 56, 57, 58};
    exp_d = '{6, 8, 14, 16};
  endtask
  initial begin
    pend = 1'b0;
    forever begin
      @(negedge clk);
      mem_opdone = 1'b0;
      if (!reset_n || op_m == 2'b00) pend = 1'b0;
      else if (!pend) begin
        pend = 1'b1;
        cnt = max_dly > 0 ? int'($urandom_range(max_dly, 0)) : 0;
        s_a = addr_m;
        s_d = data_m;
        s_op = op_m;
      end else begin
        chk("stable_addr", addr_m, s_a);
        chk("stable_op", 32'(op_m), 32'(s_op));
        if (op_m == 2'b11) chk("stable_data", data_m, s_d);
      end
      if (pend && cnt == 0) begin
        mem_opdone = 1'b1;
        pend = 1'b0;
        if (op_m == 2'b01) begin
          data_i = mem[addr_m[7:0]];
          rd_a.push_back(addr_m);
        end else begin
          mem[addr_m[7:0]] = data_m;
          wr_a.push_back(addr_m);
          wr_d.push_back(data_m);
        end
      end else if (pend) cnt--;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", ad0, 0);
    chk("rst_data", do0, 0);
    chk("rst_op", 32'(op0), 0);
    chk("rst_done", 32'(dn0), 0);
    reset_n = 1'b1;
    @(negedge clk);
    load_t1();
    en0 = 1'b1;
    run("t1");
    @(negedge clk);
    chk("t1_hold", 32'(dn0), 1);
    en0 = 1'b0;
    @(negedge clk);
    chk("drop_done", 32'(dn0), 0);
    chk("drop_op", 32'(op0), 0);
    stop();
    setup(5, 5, 1, 1);
    for (int i = 0; i < 25; i++) mem[57 + i] = 32'(i + 1);
    exp_a = '{82, 83, 84, 85};
    exp_d = '{7, 9, 17, 19};
    en0 = 1'b1;
    run("t2");
    chk("t2_nrd", 32'(rd_a.size()), 20);
    bad = 0;
    foreach (rd_a[i])
      if (rd_a[i] >= 57 && rd_a[i] < 82 && ((rd_a[i] - 57) % 5 == 4 || (rd_a[i] - 57) / 5 == 4)) bad++;
    chk("t2_skip", 32'(bad), 0);
    stop();
    setup(2, 2, 1, 1);
    mem[15] = 32'hFFFF_FFFB;
    mem[16] = 32'hFFFF_FFFD;
    mem[17] = 32'hFFFF_FFF7;
    mem[18] = 32'hFFFF_FFF9;
    exp_a = '{19};
    exp_d = '{0};
    en0 = 1'b1;
    run("t3relu");
    stop();
    setup(2, 2, 1, 1);
    mem[15] = 32'hFFFF_FFFB;
    mem[16] = 32'hFFFF_FFFD;
    mem[17] = 32'hFFFF_FFF7;
    mem[18] = 32'hFFFF_FFF9;
    exp_d = '{32'hFFFF_FFFD};
    sel = 1'b1;
    en1 = 1'b1;
    run("t3raw");
    stop();
    sel = 1'b0;
    setup(2, 2, 3, 1);
    exp_a.delete();
    exp_d.delete();
    en0 = 1'b1;
    run("t4");
    chk("t4_nrd", 32'(rd_a.size()), 4);
    stop();
    max_dly = 5;
    load_t1();
    en0 = 1'b1;
    run("t5");
    stop();
    max_dly = 3;
    load_t1();
    en0 = 1'b1;
    for (int i = 0; i < 2000 && op0 != 2'b11; i++) @(negedge clk);
    chk("t6_inwr", 32'(op0), 32'(2'b11));
    #2 reset_n = 1'b0;
    #1;
    chk("t6_addr", ad0, 0);
    chk("t6_data", do0, 0);
    chk("t6_op", 32'(op0), 0);
    chk("t6_done", 32'(dn0), 0);
    repeat (2) @(negedge clk);
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    #2 reset_n = 1'b1;
    run("t6");
    stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
